// File: rtl/br_ctrl_pkg.sv
// ============================================================================
// Module : br_ctrl_pkg
// Brief  : Shared state, opcode and mux-select encodings for br_ctrl_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package br_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BEN  = 3'd1,
        S_EVAL = 3'd2,
        S_TAKE = 3'd3,
        S_JMP  = 3'd4,
        S_JSR  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_JSR = 4'b0100;

    localparam logic [1:0] PC_PLUS1 = 2'b00;
    localparam logic [1:0] PC_BUS   = 2'b01;
    localparam logic [1:0] PC_ADDER = 2'b10;

    localparam logic [1:0] A2_ZERO  = 2'b00;
    localparam logic [1:0] A2_OFF6  = 2'b01;
    localparam logic [1:0] A2_OFF9  = 2'b10;
    localparam logic [1:0] A2_OFF11 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/br_stat_cnt.sv
// ============================================================================
// Module : br_stat_cnt
// Brief  : Saturating up-counter with synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module br_stat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/br_ctrl_seq.sv
// ============================================================================
// Module : br_ctrl_seq
// Brief  : LC-3 control-flow sequencer (BR, JMP/RET, JSR/JSRR).
//          Optional BR taken/not-taken statistics under macro BR_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module br_ctrl_seq
    import br_ctrl_pkg::*;
#(
    parameter int STAT_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [15:0]       ir,
    input  logic              ben,
    output logic              busy,
    output logic              done,
    output logic              ill_op,
    output logic              LD_BEN,
    output logic              LD_PC,
    output logic              LD_REG,
    output logic              GatePC,
    output logic [1:0]        PCMUX,
    output logic              ADDR1MUX,
    output logic [1:0]        ADDR2MUX,
    output logic              DRMUX,
    output logic              SR1MUX,
    output logic [STAT_W-1:0] taken_cnt,
    output logic [STAT_W-1:0] ntkn_cnt
);

    state_t     state;
    state_t     state_nxt;
    logic       ill_q;
    logic       ill_nxt;
    logic [3:0] opcode;
    logic       br_taken;
    logic       unused_ir_bits;

    assign opcode         = ir[15:12];
    // An empty nzp mask never branches, even if BEN was loaded high.
    assign br_taken       = ben && (ir[11:9] != 3'b000);
    assign unused_ir_bits = ^ir[8:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            ill_q <= 1'b0;
        end else begin
            state <= state_nxt;
            ill_q <= ill_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ill_nxt   = ill_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    ill_nxt = 1'b0;
                    case (opcode)
                        OP_BR:   state_nxt = S_BEN;
                        OP_JMP:  state_nxt = S_JMP;
                        OP_JSR:  state_nxt = S_JSR;
                        default: begin
                            state_nxt = S_DONE;
                            ill_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            S_BEN:   state_nxt = S_EVAL;
            S_EVAL:  state_nxt = br_taken ? S_TAKE : S_DONE;
            S_TAKE:  state_nxt = S_DONE;
            S_JMP:   state_nxt = S_DONE;
            S_JSR:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        done     = 1'b0;
        ill_op   = 1'b0;
        LD_BEN   = 1'b0;
        LD_PC    = 1'b0;
        LD_REG   = 1'b0;
        GatePC   = 1'b0;
        PCMUX    = PC_PLUS1;
        ADDR1MUX = 1'b0;
        ADDR2MUX = A2_ZERO;
        DRMUX    = 1'b0;
        SR1MUX   = 1'b0;
        case (state)
            S_BEN: LD_BEN = 1'b1;
            S_TAKE: begin
                LD_PC    = 1'b1;
                PCMUX    = PC_ADDER;
                ADDR2MUX = A2_OFF9;
            end
            S_JMP: begin
                LD_PC    = 1'b1;
                PCMUX    = PC_ADDER;
                ADDR1MUX = 1'b1;
                SR1MUX   = 1'b1;
            end
            // Link and jump share one edge, so JSRR R7 reads the old R7.
            S_JSR: begin
                LD_REG   = 1'b1;
                GatePC   = 1'b1;
                DRMUX    = 1'b1;
                LD_PC    = 1'b1;
                PCMUX    = PC_ADDER;
                SR1MUX   = 1'b1;
                ADDR1MUX = ~ir[11];
                ADDR2MUX = ir[11] ? A2_OFF11 : A2_ZERO;
            end
            S_DONE: begin
                done   = 1'b1;
                ill_op = ill_q;
            end
            default: ;
        endcase
    end

`ifdef BR_STATS_EN
    logic eval_taken;
    logic eval_ntkn;

    assign eval_taken = (state == S_EVAL) &&  br_taken;
    assign eval_ntkn  = (state == S_EVAL) && !br_taken;

    br_stat_cnt #(.WIDTH(STAT_W)) u_taken_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (eval_taken),
        .count (taken_cnt)
    );

    br_stat_cnt #(.WIDTH(STAT_W)) u_ntkn_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (eval_ntkn),
        .count (ntkn_cnt)
    );
`else
    assign taken_cnt = '0;
    assign ntkn_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_br_ctrl_seq.sv
// ============================================================================
// Module : tb_br_ctrl_seq
// Brief  : Self-checking bench for br_ctrl_seq with a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_br_ctrl_seq;

    localparam int STAT_W = 16;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       ill;
        logic       ld_ben;
        logic       ld_pc;
        logic       ld_reg;
        logic       gate_pc;
        logic [1:0] pcmux;
        logic       a1;
        logic [1:0] a2;
        logic       drmux;
        logic       sr1;
    } exp_t;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       ir = 16'h0;
    logic              ben = 1'b0;
    logic              busy, done, ill_op, LD_BEN, LD_PC, LD_REG, GatePC;
    logic [1:0]        PCMUX, ADDR2MUX;
    logic              ADDR1MUX, DRMUX, SR1MUX;
    logic [STAT_W-1:0] taken_cnt, ntkn_cnt;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_now = '0;
    exp_t        q[$];
    logic [15:0] cur_ir = 16'h0;
    logic        txn_ben = 1'b0;
    int          cyc = 0;
    int          taken_m = 0;
    int          ntkn_m = 0;

    br_ctrl_seq #(.STAT_W(STAT_W)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .ir(ir), .ben(ben),
        .busy(busy), .done(done), .ill_op(ill_op), .LD_BEN(LD_BEN),
        .LD_PC(LD_PC), .LD_REG(LD_REG), .GatePC(GatePC), .PCMUX(PCMUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .DRMUX(DRMUX),
        .SR1MUX(SR1MUX), .taken_cnt(taken_cnt), .ntkn_cnt(ntkn_cnt)
    );

    always #5 Clk = ~Clk;

    // Expected per-cycle outputs for one instruction, cycles 1..done.
    task automatic build(input logic [15:0] instr, input logic bv);
        exp_t e;
        q.delete();
        e = '0; e.busy = 1'b1;
        case (instr[15:12])
            4'b0000: begin
                e.ld_ben = 1'b1; q.push_back(e);
                e = '0; e.busy = 1'b1; q.push_back(e);
                if (bv && instr[11:9] != 3'b000) begin
                    e.ld_pc = 1'b1; e.pcmux = 2'b10; e.a1 = 1'b0; e.a2 = 2'b10;
                    q.push_back(e);
                end
            end
            4'b1100: begin
                e.ld_pc = 1'b1; e.pcmux = 2'b10; e.a1 = 1'b1; e.a2 = 2'b00; e.sr1 = 1'b1;
                q.push_back(e);
            end
            4'b0100: begin
                e.ld_reg = 1'b1; e.gate_pc = 1'b1; e.drmux = 1'b1; e.ld_pc = 1'b1;
                e.pcmux = 2'b10; e.sr1 = 1'b1;
                e.a1 = instr[11] ? 1'b0 : 1'b1;
                e.a2 = instr[11] ? 2'b11 : 2'b00;
                q.push_back(e);
            end
            default: e.ill = 1'b1;
        endcase
        e.busy = 1'b1; e.done = 1'b1;
        e.ld_ben = 0; e.ld_pc = 0; e.ld_reg = 0; e.gate_pc = 0; e.pcmux = 0;
        e.a1 = 0; e.a2 = 0; e.drmux = 0; e.sr1 = 0;
        q.push_back(e);
    endtask

    function automatic int exp_taken();
`ifdef BR_STATS_EN
        return taken_m;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_ntkn();
`ifdef BR_STATS_EN
        return ntkn_m;
`else
        return 0;
`endif
    endfunction

    // Check the current cycle at negedge, then drive the next cycle's inputs.
    task automatic step(input logic st, input logic [15:0] instr,
                        input logic bv, input logic rst);
        exp_t act;
        @(negedge Clk);
        act = {busy, done, ill_op, LD_BEN, LD_PC, LD_REG, GatePC, PCMUX,
               ADDR1MUX, ADDR2MUX, DRMUX, SR1MUX};
        checks++;
        if (act !== exp_now) begin
            errors++;
            $display("FAIL outputs t=%0t actual %h required %h", $time, act, exp_now);
        end
        checks++;
        if (int'(taken_cnt) != exp_taken() || int'(ntkn_cnt) != exp_ntkn()) begin
            errors++;
            $display("FAIL counters actual %0d/%0d required %0d/%0d",
                     taken_cnt, ntkn_cnt, exp_taken(), exp_ntkn());
        end
        if (!exp_now.busy) cur_ir = instr;
        Reset = rst;
        start = st;
        ir    = cur_ir;
        ben   = (exp_now.busy && cyc == 2 && cur_ir[15:12] == 4'b0000)
                ? txn_ben : 1'($urandom_range(0, 1));
        if (rst) begin
            q.delete();
            exp_now = '0;
            cyc     = 0;
            taken_m = 0;
            ntkn_m  = 0;
        end else begin
            if (exp_now.busy && cyc == 2 && cur_ir[15:12] == 4'b0000) begin
                if (txn_ben && cur_ir[11:9] != 3'b000) begin
                    if (taken_m < 65535) taken_m++;
                end else begin
                    if (ntkn_m < 65535) ntkn_m++;
                end
            end
            if (!exp_now.busy && st) begin
                build(cur_ir, bv);
                txn_ben = bv;
                cyc     = 0;
            end
            cyc++;
            exp_now = (q.size() > 0) ? q.pop_front() : '0;
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, req);
        end
    endtask

    task automatic run_br(input logic bv);
        step(1'b1, 16'h0E01, bv, 1'b0);
        repeat (bv ? 4 : 3) step(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic        pc_seen;
        logic [15:0] instr;
        int          sel;

        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // reset state
        step(1'b0, 16'h0, 1'b0, 1'b0);
        lit("reset_busy", {31'd0, busy}, 32'd0);

        // BRz +5, taken
        step(1'b1, 16'h0405, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        lit("brz_ld_ben_c1", {31'd0, LD_BEN}, 32'd1);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        lit("brz_take_c3", {27'd0, LD_PC, PCMUX, ADDR2MUX}, {27'd0, 5'b1_10_10});
        step(1'b0, 16'h0, 1'b0, 1'b0);
        lit("brz_done_c4", {31'd0, done}, 32'd1);

        // BR nzp=000, ben=0
        pc_seen = 1'b0;
        step(1'b1, 16'h0000, 1'b0, 1'b0);
        repeat (3) begin
            step(1'b0, 16'h0, 1'b0, 1'b0);
            pc_seen = pc_seen | LD_PC;
        end
        lit("br000_done_ill_c3", {30'd0, done, ill_op}, {30'd0, 2'b10});
        lit("br000_no_ld_pc", {31'd0, pc_seen}, 32'd0);

        // RET
        step(1'b1, 16'hC1C0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        lit("ret_c1", {27'd0, LD_PC, ADDR1MUX, ADDR2MUX, SR1MUX}, {27'd0, 5'b1_1_00_1});
        step(1'b0, 16'h0, 1'b0, 1'b0);
        lit("ret_done_c2", {31'd0, done}, 32'd1);

        // JSRR R7
        step(1'b1, 16'h41C0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        lit("jsrr_c1", {28'd0, LD_REG, LD_PC, GatePC, DRMUX}, {28'd0, 4'hF});
        step(1'b0, 16'h0, 1'b0, 1'b0);
        lit("jsrr_done_c2", {31'd0, done}, 32'd1);

        // ADD is illegal here
        step(1'b1, 16'h1000, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        lit("add_c1", {27'd0, done, ill_op, LD_BEN, LD_PC, LD_REG}, {27'd0, 5'b11000});
        step(1'b0, 16'h0, 1'b0, 1'b0);

        // start held through a BR, Reset during S_EVAL
        step(1'b1, 16'h0E03, 1'b1, 1'b0);
        step(1'b1, 16'h0E03, 1'b1, 1'b0);
        step(1'b1, 16'h0E03, 1'b1, 1'b1);
        lit("hold_no_reload_c2", {31'd0, LD_BEN}, 32'd0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        lit("after_reset_idle", {29'd0, busy, done, LD_PC}, 32'd0);

        // 3 taken + 2 not-taken branches
        run_br(1'b1); run_br(1'b0); run_br(1'b1); run_br(1'b0); run_br(1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0);
`ifdef BR_STATS_EN
        lit("taken_cnt", 32'(taken_cnt), 32'd3);
        lit("ntkn_cnt", 32'(ntkn_cnt), 32'd2);
`else
        lit("taken_cnt_tied", 32'(taken_cnt), 32'd0);
        lit("ntkn_cnt_tied", 32'(ntkn_cnt), 32'd0);
`endif

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            sel   = $urandom_range(0, 3);
            instr = 16'($urandom);
            case (sel)
                0: instr[15:12] = 4'b0000;
                1: instr[15:12] = 4'b1100;
                2: instr[15:12] = 4'b0100;
                default: ;
            endcase
            step(1'($urandom_range(0, 3) != 0), instr, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 63) == 0));
        end
        step(1'b0, 16'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
